trig_run_counter: RTL and testbench
===================================

// Module: trig_run_counter
// PURPOSE
//  Parametrised trigger-started run counter: next generation of the fixed 0..10 trigger counter.
//  Trigger starts a run; counter steps 1..limit, returns to 0 and pulses done.
//  Adds runtime limit, one-shot/auto-reload mode, hold, stop and optional retrigger.
//  Sits in the FSM timing path and supplies timeouts and step sequencing to controller FSMs.
// PARAMETERS
//  WIDTH      4   counter / limit width in bits
//  DEF_LIMIT  10  limit used when limit input == 0; elaboration error unless 1 <= DEF_LIMIT <= 2**WIDTH-1
//  RETRIGGER  0   1: trigger during RUN restarts the run; 0: trigger during RUN ignored
//  PRESCALE   4   cycles per count step (only with TRIG_RUN_CNT_PRESCALE_EN); must be >= 1
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst          in   1      synchronous reset, active-high
//  trigger      in   1      start run (level sampled each cycle)
//  limit        in   WIDTH  terminal count; latched on accepted trigger; 0 selects DEF_LIMIT
//  mode_reload  in   1      latched on accepted trigger; 1 = auto-reload, 0 = one-shot
//  hold         in   1      freeze count while high (RUN only)
//  stop         in   1      abort run: IDLE, out 0, no done
//  out          out  WIDTH  current count, registered
//  busy         out  1      high in RUN
//  done         out  1      one-cycle pulse, registered
// BEHAVIOUR
//  Clock clk; reset rst is synchronous, active-high. Reset: state IDLE, out=0, busy=0, done=0,
//   latched limit = DEF_LIMIT, latched mode = 0.
//  Priority, evaluated every edge: rst > stop > trigger(accept) > hold > count step.
//  FSM states: IDLE, RUN.
//  IDLE: out=0. Trigger accepted -> RUN; out=1 next cycle; lim_q/mode_q latched the same edge.
//  RUN, out < lim_q, !hold: out += 1 each step.
//  RUN, out == lim_q, !hold (terminal): next cycle out=0, done=1 for exactly that cycle.
//   One-shot: -> IDLE, busy=0 in the same cycle as done.
//   Reload: stay RUN, out continues 0,1,..,lim_q; busy stays 1.
//  hold=1 in RUN: out, state and prescale phase frozen; done is never raised while frozen.
//   This includes holding at out == lim_q.
//  stop=1 in RUN: next cycle IDLE, out=0, done=0. stop in IDLE has no effect.
//  Trigger accepted when in IDLE, or in RUN with RETRIGGER=1.
//   An accepted RUN retrigger sets out=1, relatches lim_q/mode_q, done=0.
//   This also applies on the terminal cycle: retrigger wins over wrap.
//  RETRIGGER=0: trigger in RUN ignored, including on the terminal cycle.
//   One-shot then goes to IDLE; a new trigger is needed.
//  Trigger + stop same cycle: stop wins -> IDLE.
//  Width rule: out is WIDTH bits and never exceeds lim_q, so there is no binary wrap past 2**WIDTH-1.
//   limit = 2**WIDTH-1 is legal.
//  Changes on limit/mode_reload during RUN are ignored until the next accepted trigger.
//  Latency: trigger -> out=1 is 1 cycle; terminal -> done is 1 cycle.
// CONFIGURATION
//  TRIG_RUN_CNT_PRESCALE_EN defined:
//   - A step occurs only on a tick, 1 cycle in every PRESCALE cycles.
//   - Phase counter clears on accepted trigger, stop and rst.
//   - First increment after a trigger comes PRESCALE cycles later; out=1 still appears 1 cycle after trigger.
//   - done stays 1 cycle wide.
//  Undefined: every cycle is a step; PRESCALE is unused; no prescale logic is generated.
// STRUCTURE
//  Package trig_run_counter_pkg:
//   - state typedef (ST_IDLE, ST_RUN)
//   - MODE_ONESHOT / MODE_RELOAD constants
//   - function resolving limit==0 -> DEF_LIMIT
//  Sub-module tick_prescaler (PRESCALE param; in: clk, rst, clr, en; out: tick).
//   Instantiated only under TRIG_RUN_CNT_PRESCALE_EN.
// TESTING
//  1 WIDTH=4, limit=0, one-shot, trigger 1 cycle -> out 1..10 on cycles 1..10;
//    cycle 11: out=0, done=1, busy=0.
//  2 limit=3, mode_reload=1 -> out 1,2,3,0,1,2,3,0; done high on each out=0 cycle; busy stays 1.
//    stop -> out=0, busy=0, no done.
//  3 hold high 3 cycles at out=5 -> out=5 for 3 cycles, then 6.
//    hold at out=lim_q delays done until hold drops.
//  4 RETRIGGER=0: trigger at out=4 ignored.
//    RETRIGGER=1: trigger at out=4 with limit=6 -> out=1 next cycle, terminal at 6.
//  5 rst at out=7 -> next cycle out=0, busy=0, done=0; trigger held with rst high -> stays IDLE.
//  6 RETRIGGER=0, one-shot, trigger on terminal cycle -> IDLE, out=0, done=1; trigger next cycle -> out=1.
//    With TRIG_RUN_CNT_PRESCALE_EN and PRESCALE=4: increments every 4 cycles.

Source files
------------

// File: rtl/trig_run_counter_pkg.sv
// Shared state encoding, mode constants and limit resolution for trig_run_counter.
// Pure declarations: no logic, no timing of its own.
package trig_run_counter_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

   // A zero limit on the input selects the elaboration-time default.
   function automatic int unsigned resolve_limit(input int unsigned lim,
                                                 input int unsigned def_lim);
      return (lim == 0) ? def_lim : lim;
   endfunction

endpackage

// File: rtl/trig_run_counter_tick.sv
// tick_prescaler: one tick every PRESCALE enabled cycles, combinational tick, no backpressure.
// Built only with TRIG_RUN_CNT_PRESCALE_EN; phase frozen while i_en is low, cleared by i_rst/i_clr.
`ifdef TRIG_RUN_CNT_PRESCALE_EN
module tick_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_phase;
   logic          w_last;

   assign w_last = (r_phase == LAST);
   assign o_tick = i_en & w_last;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_phase <= '0;
      end else if (i_en) begin
         r_phase <= w_last ? '0 : r_phase + PW'(1);
      end
   end

endmodule
`endif

// File: rtl/trig_run_counter.sv
// Trigger-started run counter 1..limit with wrap-to-0 done pulse; trigger->out=1 and terminal->done 1 cycle, no backpressure.
// Optional step prescaler enabled by defining TRIG_RUN_CNT_PRESCALE_EN.
module trig_run_counter
   import trig_run_counter_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int unsigned DEF_LIMIT = 10,
   parameter int          RETRIGGER = 0,
   parameter int          PRESCALE  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_trigger,
   input  logic [WIDTH-1:0] i_limit,
   input  logic             i_mode_reload,
   input  logic             i_hold,
   input  logic             i_stop,
   output logic [WIDTH-1:0] o_out,
   output logic             o_busy,
   output logic             o_done
);

   if (DEF_LIMIT < 1 || DEF_LIMIT > (2**WIDTH) - 1) begin : g_bad_def_limit
      $error("trig_run_counter: DEF_LIMIT must lie in 1..2**WIDTH-1");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("trig_run_counter: PRESCALE must be >= 1");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_lim;
   logic             r_mode;
   logic             r_done;

   logic             w_run;
   logic             w_trig_acc;
   logic             w_step;
   logic             w_terminal;
   logic [WIDTH-1:0] w_lim_res;

   assign w_run      = (r_state == ST_RUN);
   assign w_trig_acc = i_trigger && (!w_run || (RETRIGGER != 0));
   assign w_terminal = (r_out == r_lim);
   assign w_lim_res  = WIDTH'(resolve_limit(32'(i_limit), DEF_LIMIT));

`ifdef TRIG_RUN_CNT_PRESCALE_EN
   logic w_tick;

   // Phase restarts on any run start or abort so the first step is a full period away.
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_trig_acc | i_stop),
      .i_en   (w_run & ~i_hold),
      .o_tick (w_tick)
   );

   assign w_step = w_tick;
`else
   assign w_step = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_lim   <= WIDTH'(DEF_LIMIT);
         r_mode  <= MODE_ONESHOT;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_stop) begin
            // Stop also masks a simultaneous trigger, so IDLE is kept as well.
            r_state <= ST_IDLE;
            r_out   <= '0;
         end else if (w_trig_acc) begin
            r_state <= ST_RUN;
            r_out   <= WIDTH'(1);
            r_lim   <= w_lim_res;
            r_mode  <= i_mode_reload;
         end else if (w_run && !i_hold && w_step) begin
            if (w_terminal) begin
               r_out  <= '0;
               r_done <= 1'b1;
               if (r_mode == MODE_ONESHOT) begin
                  r_state <= ST_IDLE;
               end
            end else begin
               r_out <= r_out + WIDTH'(1);
            end
         end
      end
   end

   assign o_out  = r_out;
   assign o_busy = w_run;
   assign o_done = r_done;

endmodule

// File: tb/tb_trig_run_counter.sv
// Bench for trig_run_counter: one instance without and one with retrigger, fed identical stimulus.
// Expected {out,busy,done} per edge are queued by the stimulus and popped by a separate monitor.
module tb_trig_run_counter;

   logic       clk         = 1'b0;
   logic       rst         = 1'b1;
   logic       trigger     = 1'b0;
   logic [3:0] limit       = 4'd0;
   logic       mode_reload = 1'b0;
   logic       hold        = 1'b0;
   logic       stop        = 1'b0;

   logic [3:0] out0, out1;
   logic       busy0, busy1, done0, done1;

   typedef struct packed {
      logic [3:0] out;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      obs_t v;
      int   n;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   total = 0;
   int   bad   = 0;
   int   nstep = 0;

   always #5 clk = ~clk;

   trig_run_counter #(
      .WIDTH(4), .DEF_LIMIT(10), .RETRIGGER(0), .PRESCALE(4)
   ) dut0 (
      .i_clk(clk), .i_rst(rst), .i_trigger(trigger), .i_limit(limit),
      .i_mode_reload(mode_reload), .i_hold(hold), .i_stop(stop),
      .o_out(out0), .o_busy(busy0), .o_done(done0)
   );

   trig_run_counter #(
      .WIDTH(4), .DEF_LIMIT(10), .RETRIGGER(1), .PRESCALE(4)
   ) dut1 (
      .i_clk(clk), .i_rst(rst), .i_trigger(trigger), .i_limit(limit),
      .i_mode_reload(mode_reload), .i_hold(hold), .i_stop(stop),
      .o_out(out1), .o_busy(busy1), .o_done(done1)
   );

   // Push expectations for the next edge (retrig=0 instance, retrig=1 instance), then clock it.
   task automatic tick2(input int o0, input int b0, input int d0,
                        input int o1, input int b1, input int d1);
      exp_t e;
      e.n      = nstep;
      e.v.out  = 4'(o0);
      e.v.busy = 1'(b0);
      e.v.done = 1'(d0);
      q0.push_back(e);
      e.v.out  = 4'(o1);
      e.v.busy = 1'(b1);
      e.v.done = 1'(d1);
      q1.push_back(e);
      nstep++;
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int o, input int b, input int d);
      tick2(o, b, d, o, b, d);
   endtask

   // Monitor: outputs settle after each edge and are sampled on the following falling edge.
   always begin
      exp_t e;
      obs_t a;
      @(posedge clk);
      @(negedge clk);
      if (q0.size() > 0) begin
         e = q0.pop_front();
         a = {out0, busy0, done0};
         total++;
         if (a !== e.v) begin
            bad++;
            $display("FAIL rt0 step %0d: got out=%0d busy=%0b done=%0b, want out=%0d busy=%0b done=%0b",
                     e.n, a.out, a.busy, a.done, e.v.out, e.v.busy, e.v.done);
         end
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         a = {out1, busy1, done1};
         total++;
         if (a !== e.v) begin
            bad++;
            $display("FAIL rt1 step %0d: got out=%0d busy=%0b done=%0b, want out=%0d busy=%0b done=%0b",
                     e.n, a.out, a.busy, a.done, e.v.out, e.v.busy, e.v.done);
         end
      end
   end

   initial begin
      // Reset state
      rst = 1'b1;
      tick(0, 0, 0);
      tick(0, 0, 0);
      rst = 1'b0;
      tick(0, 0, 0);

`ifndef TRIG_RUN_CNT_PRESCALE_EN
      // Default limit, one-shot: 1..10 then wrap with done and busy low together
      limit = 4'd0; mode_reload = 1'b0; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      for (int v = 2; v <= 10; v++) tick(v, 1, 0);
      tick(0, 0, 1);
      tick(0, 0, 0);

      // limit=3 auto-reload; input changes during RUN ignored; stop+trigger aborts without done
      limit = 4'd3; mode_reload = 1'b1; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0; limit = 4'd0; mode_reload = 1'b0;
      tick(2, 1, 0); tick(3, 1, 0); tick(0, 1, 1);
      tick(1, 1, 0); tick(2, 1, 0); tick(3, 1, 0); tick(0, 1, 1);
      tick(1, 1, 0);
      stop = 1'b1; trigger = 1'b1;
      tick(0, 0, 0);
      trigger = 1'b0;
      tick(0, 0, 0);
      stop = 1'b0;
      tick(0, 0, 0);

      // limit=1 reload: alternates 1 / 0+done
      limit = 4'd1; mode_reload = 1'b1; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      tick(0, 1, 1); tick(1, 1, 0); tick(0, 1, 1);
      stop = 1'b1;
      tick(0, 0, 0);
      stop = 1'b0;

      // hold at 5 for 3 cycles, then hold on the terminal value delays done
      limit = 4'd0; mode_reload = 1'b0; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      for (int v = 2; v <= 5; v++) tick(v, 1, 0);
      hold = 1'b1;
      tick(5, 1, 0); tick(5, 1, 0); tick(5, 1, 0);
      hold = 1'b0;
      for (int v = 6; v <= 10; v++) tick(v, 1, 0);
      hold = 1'b1;
      tick(10, 1, 0); tick(10, 1, 0);
      hold = 1'b0;
      tick(0, 0, 1);
      tick(0, 0, 0);

      // Trigger at out=4 with limit=6: ignored without retrigger, restart with it
      limit = 4'd8; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      tick(2, 1, 0); tick(3, 1, 0); tick(4, 1, 0);
      trigger = 1'b1; limit = 4'd6;
      tick2(5, 1, 0, 1, 1, 0);
      trigger = 1'b0; limit = 4'd0;
      tick2(6, 1, 0, 2, 1, 0);
      tick2(7, 1, 0, 3, 1, 0);
      tick2(8, 1, 0, 4, 1, 0);
      tick2(0, 0, 1, 5, 1, 0);
      tick2(0, 0, 0, 6, 1, 0);
      tick2(0, 0, 0, 0, 0, 1);
      tick(0, 0, 0);

      // rst mid-run at out=7; trigger held under rst stays IDLE
      trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      for (int v = 2; v <= 7; v++) tick(v, 1, 0);
      rst = 1'b1;
      tick(0, 0, 0);
      trigger = 1'b1;
      tick(0, 0, 0);
      rst = 1'b0; trigger = 1'b0;
      tick(0, 0, 0);

      // Trigger on terminal cycle: wrap+done without retrigger, restart with it; new trigger latches default
      limit = 4'd2; mode_reload = 1'b0; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      tick(2, 1, 0);
      trigger = 1'b1; limit = 4'd0;
      tick2(0, 0, 1, 1, 1, 0);
      tick(1, 1, 0);
      trigger = 1'b0;
      for (int v = 2; v <= 10; v++) tick(v, 1, 0);
      tick(0, 0, 1);

      // Maximum legal limit 15: no binary wrap before the terminal
      limit = 4'd15; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      for (int v = 2; v <= 15; v++) tick(v, 1, 0);
      tick(0, 0, 1);
      tick(0, 0, 0);
`else
      // PRESCALE=4: out=1 right after trigger, then a step every 4 cycles
      limit = 4'd2; mode_reload = 1'b0; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
      tick(2, 1, 0); tick(2, 1, 0); tick(2, 1, 0); tick(2, 1, 0);
      tick(0, 0, 1);
      tick(0, 0, 0);

      // hold freezes the phase; reload wrap, done one cycle wide
      limit = 4'd1; mode_reload = 1'b1; trigger = 1'b1;
      tick(1, 1, 0);
      trigger = 1'b0;
      tick(1, 1, 0);
      hold = 1'b1;
      tick(1, 1, 0); tick(1, 1, 0);
      hold = 1'b0;
      tick(1, 1, 0); tick(1, 1, 0);
      tick(0, 1, 1);
      tick(0, 1, 0); tick(0, 1, 0); tick(0, 1, 0);
      tick(1, 1, 0);
      stop = 1'b1;
      tick(0, 0, 0);
      stop = 1'b0;
      tick(0, 0, 0);
`endif

      @(negedge clk);
      #1;
      total++;
      if (q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d/%0d entries left, want 0/0", q0.size(), q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus by 200000, want finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
